// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared constants and state encodings for the AXI4-Lite RAM responder.
//   DATA_W / STRB_W         : data bus width and byte-strobe width
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   wr_state_e / rd_state_e : write-path and read-path FSM states
package axi_lite_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_RESP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_RESP
  } rd_state_e;

endpackage

// File: rtl/ram_1r1w_bytewe.sv
// ram_1r1w_bytewe: word-addressed RAM, one byte-enabled write port and one
// synchronous read port. No reset, so it maps onto block RAM.
//   clk        : clock
//   we         : write enable
//   waddr      : write word index
//   wstrb      : byte enables, bit i -> byte lane i
//   wdata      : write data
//   re         : read enable; rdata holds its value while re is low
//   raddr      : read word index
//   rdata      : registered read data (pre-write contents on a same-word collision)
module ram_1r1w_bytewe
  import axi_lite_pkg::*;
#(
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [STRB_W-1:0] wstrb,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi_lite_ram_slave.sv
// axi_lite_ram_slave: AXI4-Lite responder backed by on-chip RAM with byte-strobe
// writes. Independent write and read paths, one outstanding transaction each.
// Optional build macro: AXI_RAM_RANGE_CHECK_EN -- when defined, out-of-range
// accesses answer SLVERR (writes dropped, reads return zero); when undefined
// the word index simply wraps modulo DEPTH_WORDS and every response is OKAY.
//   s_axi_aclk / s_axi_areset : clock, asynchronous active-high reset
//   s_axi_aw*                 : write address channel
//   s_axi_w*                  : write data channel (wstrb byte enables)
//   s_axi_b*                  : write response channel
//   s_axi_ar*                 : read address channel
//   s_axi_r*                  : read data channel
module axi_lite_ram_slave
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_areset,
  input  logic [31:0]       s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [STRB_W-1:0] s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [31:0]       s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);

  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);
  typedef logic [ADDR_W-1:0] idx_t;

  function automatic idx_t word_index(input logic [31:0] addr);
    return idx_t'((addr - BASE_ADDR) >> 2);
  endfunction

`ifdef AXI_RAM_RANGE_CHECK_EN
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  function automatic logic in_range(input logic [31:0] addr);
    return ({1'b0, addr - BASE_ADDR} < SPAN);
  endfunction
`endif

  // ---------------- write path ----------------
  wr_state_e         wr_state, wr_next;
  logic              wr_commit;
  logic [31:0]       awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [31:0]       wr_addr_sel;
  logic [DATA_W-1:0] wr_data_sel;
  logic [STRB_W-1:0] wr_strb_sel;
  logic              wr_ok;
  logic              aw_hs, w_hs;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid  && s_axi_wready;

  // The commit edge is the edge of the later handshake: the channel arriving
  // now is taken straight from the bus, the earlier one from its latch.
  assign wr_addr_sel = (wr_state == WR_HAVE_AW) ? awaddr_q : s_axi_awaddr;
  assign wr_data_sel = (wr_state == WR_HAVE_W)  ? wdata_q  : s_axi_wdata;
  assign wr_strb_sel = (wr_state == WR_HAVE_W)  ? wstrb_q  : s_axi_wstrb;

  always_comb begin
    wr_next   = wr_state;
    wr_commit = 1'b0;
    unique case (wr_state)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_next   = WR_RESP;
          wr_commit = 1'b1;
        end else if (aw_hs) begin
          wr_next = WR_HAVE_AW;
        end else if (w_hs) begin
          wr_next = WR_HAVE_W;
        end
      end
      WR_HAVE_AW: begin
        if (w_hs) begin
          wr_next   = WR_RESP;
          wr_commit = 1'b1;
        end
      end
      WR_HAVE_W: begin
        if (aw_hs) begin
          wr_next   = WR_RESP;
          wr_commit = 1'b1;
        end
      end
      WR_RESP: begin
        if (s_axi_bvalid && s_axi_bready) wr_next = WR_IDLE;
      end
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      wr_state      <= WR_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
    end else begin
      wr_state <= wr_next;
      // Readys stay low for one extra cycle after a response completes, so a
      // write takes at least three cycles even with bready tied high.
      s_axi_awready <= ((wr_next == WR_IDLE) || (wr_next == WR_HAVE_W)) &&
                       (wr_state != WR_RESP);
      s_axi_wready  <= ((wr_next == WR_IDLE) || (wr_next == WR_HAVE_AW)) &&
                       (wr_state != WR_RESP);
      s_axi_bvalid  <= (wr_next == WR_RESP);
      if (aw_hs) awaddr_q <= s_axi_awaddr;
      if (w_hs) begin
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (wr_commit) s_axi_bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // ---------------- read path ----------------
  rd_state_e         rd_state, rd_next;
  logic              ar_hs;
  logic              rd_ok;
  logic              rd_zero;
  logic [DATA_W-1:0] ram_q;

  assign ar_hs = s_axi_arvalid && s_axi_arready;

  always_comb begin
    rd_next = rd_state;
    unique case (rd_state)
      RD_IDLE: if (ar_hs) rd_next = RD_RESP;
      RD_RESP: if (s_axi_rvalid && s_axi_rready) rd_next = RD_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      rd_state      <= RD_IDLE;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      rd_zero       <= 1'b1;
    end else begin
      rd_state      <= rd_next;
      s_axi_arready <= (rd_next == RD_IDLE);
      s_axi_rvalid  <= (rd_next == RD_RESP);
      if (ar_hs) begin
        s_axi_rresp <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        rd_zero     <= !rd_ok;
      end
    end
  end

  // The RAM output register has no reset; rd_zero forces rdata to zero after
  // reset and for rejected reads without disturbing block-RAM inference.
  assign s_axi_rdata = rd_zero ? '0 : ram_q;

`ifdef AXI_RAM_RANGE_CHECK_EN
  assign wr_ok = in_range(wr_addr_sel);
  assign rd_ok = in_range(s_axi_araddr);
`else
  assign wr_ok = 1'b1;
  assign rd_ok = 1'b1;
`endif

  ram_1r1w_bytewe #(
    .DEPTH  (DEPTH_WORDS),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (s_axi_aclk),
    .we    (wr_commit && wr_ok),
    .waddr (word_index(wr_addr_sel)),
    .wstrb (wr_strb_sel),
    .wdata (wr_data_sel),
    .re    (ar_hs),
    .raddr (word_index(s_axi_araddr)),
    .rdata (ram_q)
  );

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// tb_axi_lite_ram_slave: directed, table-driven bench for axi_lite_ram_slave
// (BASE_ADDR = 32'h1000_0000, DEPTH_WORDS = 64, so the span is 0x100 bytes).
module tb_axi_lite_ram_slave;

  localparam logic [31:0] B = 32'h1000_0000;
  localparam int unsigned DEPTH = 64;

`ifdef AXI_RAM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] ERR = 2'b10;
  localparam logic [1:0] OOR_RESP = RC ? ERR : OK;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axi_lite_ram_slave #(
    .BASE_ADDR   (B),
    .DEPTH_WORDS (DEPTH)
  ) dut (
    .s_axi_aclk    (clk),
    .s_axi_areset  (rst),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready)
  );

  typedef struct {
    int          mode;   // 0: AW then W two cycles later, 1: W then AW, 2: same cycle
    logic [31:0] waddr;
    logic [31:0] wdat;
    logic [3:0]  wstb;
    logic [1:0]  bexp;
    logic [31:0] raddr;
    logic [31:0] rexp;
    logic [1:0]  rrexp;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel: 0 AW, 1 W, 2 AW+W, 3 AR, 4 AW+W+AR
  function automatic bit rdy(input int sel);
    case (sel)
      0:       return awready;
      1:       return wready;
      2:       return awready && wready;
      3:       return arready;
      default: return awready && wready && arready;
    endcase
  endfunction

  // Valids are already driven; wait (bounded) for the ready(s), take the
  // handshake edge and drop the valids. Returns at edge + 1.
  task automatic handshake(input int sel, input string tag);
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rdy(sel)) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check({tag, " hs_timeout"}, 32'(got), 32'd1);
    tick();
    if (sel == 0 || sel == 2 || sel == 4) awvalid = 1'b0;
    if (sel == 1 || sel == 2 || sel == 4) wvalid = 1'b0;
    if (sel == 3 || sel == 4) arvalid = 1'b0;
  endtask

  task automatic axi_write(input int mode, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] exp_resp, input string tag);
    awaddr = a;
    wdata  = d;
    wstrb  = s;
    case (mode)
      0: begin
        awvalid = 1'b1;
        handshake(0, tag);
        tick();
        tick();
        check({tag, " awready_held_low"}, 32'(awready), 32'd0);
        check({tag, " bvalid_waiting_w"}, 32'(bvalid), 32'd0);
        wvalid = 1'b1;
        handshake(1, tag);
      end
      1: begin
        wvalid = 1'b1;
        handshake(1, tag);
        check({tag, " wready_dropped"}, 32'(wready), 32'd0);
        awvalid = 1'b1;
        handshake(0, tag);
      end
      default: begin
        awvalid = 1'b1;
        wvalid  = 1'b1;
        handshake(2, tag);
      end
    endcase
    check({tag, " bvalid_latency"}, 32'(bvalid), 32'd1);
    check({tag, " bresp"}, 32'(bresp), 32'(exp_resp));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check({tag, " bvalid_cleared"}, 32'(bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [31:0] exp_d,
                          input logic [1:0] exp_resp, input string tag);
    araddr  = a;
    arvalid = 1'b1;
    handshake(3, tag);
    check({tag, " rvalid_latency"}, 32'(rvalid), 32'd1);
    check({tag, " rdata"}, rdata, exp_d);
    check({tag, " rresp"}, 32'(rresp), 32'(exp_resp));
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check({tag, " rvalid_cleared"}, 32'(rvalid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " awready"}, 32'(awready), 32'd0);
    check({tag, " wready"},  32'(wready),  32'd0);
    check({tag, " arready"}, 32'(arready), 32'd0);
    check({tag, " bvalid"},  32'(bvalid),  32'd0);
    check({tag, " rvalid"},  32'(rvalid),  32'd0);
    check({tag, " bresp"},   32'(bresp),   32'd0);
    check({tag, " rresp"},   32'(rresp),   32'd0);
    check({tag, " rdata"},   rdata,        32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{0, B + 32'h10,  32'hDEAD_BEEF, 4'hF, OK, B + 32'h10,  32'hDEAD_BEEF, OK};
    vecs[1]  = '{1, B + 32'h20,  32'hA5A5_5A5A, 4'hF, OK, B + 32'h20,  32'hA5A5_5A5A, OK};
    vecs[2]  = '{0, B + 32'h20,  32'h0000_0000, 4'hF, OK, B + 32'h20,  32'h0000_0000, OK};
    vecs[3]  = '{2, B + 32'h20,  32'hA5A5_5A5A, 4'hF, OK, B + 32'h20,  32'hA5A5_5A5A, OK};
    vecs[4]  = '{2, B + 32'h30,  32'hFFFF_FFFF, 4'hF, OK, B + 32'h30,  32'hFFFF_FFFF, OK};
    vecs[5]  = '{1, B + 32'h30,  32'h1122_3344, 4'h5, OK, B + 32'h30,  32'hFF22_FF44, OK};
    vecs[6]  = '{0, B + 32'h30,  32'h0000_0000, 4'h0, OK, B + 32'h30,  32'hFF22_FF44, OK};
    vecs[7]  = '{2, B + 32'h43,  32'h0102_0304, 4'hF, OK, B + 32'h40,  32'h0102_0304, OK};
    vecs[8]  = '{0, B,           32'h0BAD_0000, 4'hF, OK, B,           32'h0BAD_0000, OK};
    vecs[9]  = '{1, B + 32'h100, 32'h7777_7777, 4'hF, OOR_RESP, B,
                 RC ? 32'h0BAD_0000 : 32'h7777_7777, OK};
    vecs[10] = '{2, B + 32'h104, 32'h0000_0099, 4'hF, OOR_RESP, B + 32'h104,
                 RC ? 32'h0 : 32'h0000_0099, OOR_RESP};
    vecs[11] = '{2, B + 32'hFC,  32'h1234_5678, 4'hF, OK, B + 32'hFC,  32'h1234_5678, OK};
    vecs[12] = '{1, B - 32'h4,   32'h0000_CAFE, 4'hF, OOR_RESP, B + 32'hFC,
                 RC ? 32'h1234_5678 : 32'h0000_CAFE, OK};

    // Reset state, held across clock edges.
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    #2;
    check("readys_before_first_edge", 32'(awready), 32'd0);
    tick();
    check("awready_after_reset", 32'(awready), 32'd1);
    check("wready_after_reset",  32'(wready),  32'd1);
    check("arready_after_reset", 32'(arready), 32'd1);

    for (int i = 0; i < 13; i++) begin
      axi_write(vecs[i].mode, vecs[i].waddr, vecs[i].wdat, vecs[i].wstb, vecs[i].bexp,
                $sformatf("v%0d_wr", i));
      axi_read(vecs[i].raddr, vecs[i].rexp, vecs[i].rrexp, $sformatf("v%0d_rd", i));
    end

    // Write response backpressure.
    awaddr = B + 32'h50; wdata = 32'h5555_AAAA; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    handshake(2, "bp_wr");
    for (int i = 0; i < 5; i++) begin
      check("bp_wr bvalid_held", 32'(bvalid), 32'd1);
      check("bp_wr bresp_held", 32'(bresp), 32'(OK));
      check("bp_wr readys_low", {30'd0, awready, wready}, 32'd0);
      tick();
    end
    bready = 1'b1; tick(); bready = 1'b0;
    check("bp_wr bvalid_cleared", 32'(bvalid), 32'd0);

    // Read data backpressure.
    araddr = B + 32'h50; arvalid = 1'b1;
    handshake(3, "bp_rd");
    for (int i = 0; i < 5; i++) begin
      check("bp_rd rvalid_held", 32'(rvalid), 32'd1);
      check("bp_rd rdata_held", rdata, 32'h5555_AAAA);
      check("bp_rd arready_low", 32'(arready), 32'd0);
      tick();
    end
    rready = 1'b1; tick(); rready = 1'b0;

    // Read and write of the same word on the same edge: read sees old data.
    tick();
    awaddr = B + 32'h50; wdata = 32'h6666_7777; wstrb = 4'hF; araddr = B + 32'h50;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    handshake(4, "rw_same");
    check("rw_same bvalid", 32'(bvalid), 32'd1);
    check("rw_same rvalid", 32'(rvalid), 32'd1);
    check("rw_same rdata_old", rdata, 32'h5555_AAAA);
    bready = 1'b1; rready = 1'b1; tick(); bready = 1'b0; rready = 1'b0;
    axi_read(B + 32'h50, 32'h6666_7777, OK, "rw_same_after");

    // Reset between the AW and W handshakes discards the latched address.
    awaddr = B + 32'h50; awvalid = 1'b1;
    handshake(0, "mid_rst");
    rst = 1'b1;
    #2;
    check_reset_outputs("mid_rst");
    tick();
    rst = 1'b0;
    tick();
    check("mid_rst awready_back", 32'(awready), 32'd1);
    check("mid_rst wready_back", 32'(wready), 32'd1);
    axi_write(1, B + 32'h58, 32'h0F0F_0F0F, 4'hF, OK, "post_rst_wr");
    axi_read(B + 32'h50, 32'h6666_7777, OK, "post_rst_old_word");
    axi_read(B + 32'h58, 32'h0F0F_0F0F, OK, "post_rst_new_word");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
